// File: rtl/siggen_pkg.sv
// Shared types and default sizes for the signal-generator controller slice.
package siggen_pkg;

  localparam int DEF_WIDTH = 9;
  localparam int DEF_DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/tick_div.sv
// Programmable tick divider: tick is high once every div+1 cycles while clr is low.
module tick_div
  import siggen_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] divcnt;

  // The >= guard keeps the count bounded even if div ever shrinks below it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      divcnt <= '0;
    else if (clr || divcnt >= div)
      divcnt <= '0;
    else
      divcnt <= divcnt + DIV_W'(1);
  end

  assign tick = (divcnt == div);

endmodule

// File: rtl/siggen_ctrl.sv
// Controller for the dual-address counter: sequences reset/enable and applies
// new rate/offset configurations only at IDLE or at a counter wrap.
module siggen_ctrl
  import siggen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_offset,
  input  logic [WIDTH-1:0] count1,
  output logic             cnt_rst,
  output logic             cnt_en,
  output logic [WIDTH-1:0] cnt_offset,
  output logic             wrap,
  output logic [1:0]       state
);

  state_t           st;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] pend_div;
  logic [WIDTH-1:0] off_q;
  logic [WIDTH-1:0] pend_off;
  logic             pend_flag;
  logic             cfg_take;
  logic             tick;

  assign cfg_ready = !pend_flag;
  assign cfg_take  = cfg_valid && cfg_ready;

  tick_div #(.DIV_W(DIV_W)) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (st != RUN),
    .div  (div_q),
    .tick (tick)
  );

  assign cnt_rst    = (st == LOAD);
  assign cnt_en     = (st == RUN) && tick;
  assign wrap       = cnt_en && (count1 == '1);
  assign cnt_offset = off_q;
  assign state      = st;

  // Active values only change in IDLE or on the RUN->LOAD edge, so the
  // counter never sees an offset change while it is running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      div_q     <= '0;
      off_q     <= '0;
      pend_div  <= '0;
      pend_off  <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (cfg_take) begin
        pend_div  <= cfg_div;
        pend_off  <= cfg_offset;
        pend_flag <= 1'b1;
      end
      case (st)
        IDLE: begin
          if (pend_flag) begin
            div_q     <= pend_div;
            off_q     <= pend_off;
            pend_flag <= 1'b0;
          end
          if (start && !stop)
            st <= LOAD;
        end
        LOAD: st <= stop ? IDLE : RUN;
        RUN: begin
          if (stop)
            st <= IDLE;
          else if (wrap && pend_flag) begin
            div_q     <= pend_div;
            off_q     <= pend_off;
            pend_flag <= 1'b0;
            st        <= LOAD;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/siggen_ctrl.md
SIGGEN_CTRL -- requirements
Module: siggen_ctrl

Interface
REQ-001 Parameter WIDTH, default 9: address width of the dual-address counter it drives.
REQ-002 Parameter DIV_W, default 8: width of the tick divider.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  pulse; begin generation from IDLE.
REQ-006 stop  input  1  pulse; halt generation.
REQ-007 cfg_valid  input  1  a new configuration is offered.
REQ-008 cfg_ready  output  1  controller can accept a configuration.
REQ-009 cfg_div  input  DIV_W  counter-enable period minus 1.
REQ-010 cfg_offset  input  WIDTH  phase offset between the two addresses.
REQ-011 count1  input  WIDTH  current primary count, fed back from the counter.
REQ-012 cnt_rst  output  1  synchronous reset to the counter.
REQ-013 cnt_en  output  1  increment enable to the counter.
REQ-014 cnt_offset  output  WIDTH  offset to the counter.
REQ-015 wrap  output  1  one-cycle pulse when count1 wraps.
REQ-016 state  output  2  current FSM state.

Function
REQ-017 The controller SHALL hold active registers div_q and off_q, plus pending registers pend_div, pend_off and pend_flag.
REQ-018 cfg_ready SHALL equal !pend_flag.
REQ-019 A handshake (cfg_valid && cfg_ready) SHALL capture cfg_div/cfg_offset into the pending registers and set pend_flag at the same edge.
REQ-020 cnt_offset SHALL equal off_q.
REQ-021 The FSM SHALL have three states: IDLE=0, LOAD=1, RUN=2; the value 3 SHALL return to IDLE.
REQ-022 IDLE: cnt_en=0 and cnt_rst=0; if pend_flag=1, pending SHALL be copied to active and pend_flag cleared on the next edge; start SHALL move the FSM to LOAD.
REQ-023 LOAD: cnt_rst=1 for exactly one cycle, divider count cleared, next state RUN.
REQ-024 RUN: divcnt SHALL count 0..div_q; cnt_en=1 only in the cycle where divcnt==div_q, after which divcnt returns to 0; div_q=0 gives cnt_en every cycle.
REQ-025 cnt_en and cnt_rst SHALL be decoded from registered state and divcnt only.
REQ-026 wrap SHALL equal (state==RUN && cnt_en && count1 == all-ones).
REQ-027 When wrap=1 and pend_flag=1, the controller SHALL copy pending to active, clear pend_flag and enter LOAD, so the counter restarts at 0 with the new offset; this inserts one extra cycle at count1=0 by design.
REQ-028 When wrap=1 and pend_flag=0, the controller SHALL stay in RUN.
REQ-029 A configuration accepted in the same cycle as a wrap SHALL NOT apply at that wrap; it SHALL apply at the next wrap.
REQ-030 stop in LOAD or RUN SHALL move the FSM to IDLE on the next edge; the counter then holds its value; pending configuration is kept.
REQ-031 stop SHALL take priority over start when both are asserted; start outside IDLE SHALL be ignored.
REQ-032 All cnt_rst, cnt_en and cnt_offset changes SHALL be glitch-free (no offset change while state==RUN).

Reset
REQ-033 Asserting rst SHALL, without a clock, set state=IDLE, div_q=0, off_q=0, divcnt=0 and pend_flag=0, giving cnt_en=0, cnt_rst=0, cnt_offset=0, wrap=0 and cfg_ready=1.
REQ-034 Reset mid-operation SHALL discard any pending configuration; operation SHALL resume only on a start after rst deasserts.

Structure
REQ-035 Package siggen_pkg SHALL hold state_t (IDLE, LOAD, RUN) and the default WIDTH and DIV_W constants.
REQ-036 The divider SHALL be a sub-module tick_div (inputs clk, rst, clr, div; output tick).
REQ-037 siggen_ctrl SHALL instantiate tick_div and, in the top-level bench, drive the existing counter module.

Verification
REQ-038 Reset, then cfg div=0/off=64 in IDLE, then start -> one LOAD cycle with cnt_rst=1 and cnt_offset=64, then cnt_en=1 every cycle.
REQ-039 div=3 in RUN -> cnt_en high 1 cycle in 4, first on the 4th RUN cycle; count1 advances 1 per 4 cycles.
REQ-040 cfg off=128 accepted at count1=100 -> cfg_ready=0 until the wrap; at count1=511 with cnt_en, wrap=1; next cycle LOAD with cnt_offset=128, then RUN with count1=0.
REQ-041 Second cfg_valid while pending -> not accepted and active values unchanged; stop and start together in RUN -> IDLE.
REQ-042 rst asserted mid-RUN with pend_flag=1 -> all outputs at reset values and cfg_ready=1 immediately; start after release -> LOAD with cnt_offset=0.
